// File: rtl/smem_rr_arbiter.sv
// smem_rr_arbiter: round-robin arbiter sharing one single-port synchronous
// memory between requesters A and B, with bounded bursts and read-return
// routing back to the issuing requester.
//
// Optional feature macro: SMEM_ARB_PARITY_CHK_EN (read parity checking).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     requester A command (held until a_gnt)
//   a_gnt                         A command accepted this cycle
//   a_rvalid/a_rdata              A read return (rdata holds when !rvalid)
//   b_*                           same group for requester B
//   mem_din/mem_addr/mem_wr_en/mem_rd_en/mem_blk_select   memory command
//   mem_addr_en/mem_dout_en       static memory configuration pins
//   mem_dout/mem_parity           memory read data and parity
//   rd_parity_err                 one-cycle parity mismatch pulse
module smem_rr_arbiter #(
    parameter int unsigned MEM_WIDTH  = 16,
    parameter int unsigned ADDR_SIZE  = 10,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic [MEM_WIDTH-1:0] mem_din,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic                 mem_blk_select,
    output logic                 mem_addr_en,
    output logic                 mem_dout_en,
    input  logic [MEM_WIDTH-1:0] mem_dout,
    input  logic                 mem_parity,
    output logic                 rd_parity_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned LAST  = RD_LATENCY - 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   last_b, last_b_nxt;
    logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt;
    logic                   grant_a, grant_b;
    logic [RD_LATENCY-1:0]  rd_vld;
    logic [RD_LATENCY-1:0]  rd_id;
    logic [MEM_WIDTH-1:0]   a_rdata_q, b_rdata_q;

    // Ownership state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_b    <= last_b_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant decision and next ownership
    always_comb begin
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        state_nxt     = state;
        last_b_nxt    = last_b;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (a_req && (!b_req || last_b)) begin
                    grant_a       = 1'b1;
                    state_nxt     = OWN_A;
                    burst_cnt_nxt = CNT_ONE;
                end else if (b_req) begin
                    grant_b       = 1'b1;
                    state_nxt     = OWN_B;
                    burst_cnt_nxt = CNT_ONE;
                end
            end
            OWN_A: begin
                if (a_req && !(b_req && burst_cnt == BURST_MAX)) begin
                    grant_a = 1'b1;
                    if (burst_cnt != BURST_MAX)
                        burst_cnt_nxt = burst_cnt + CNT_ONE;
                end else if (b_req) begin
                    grant_b       = 1'b1;
                    state_nxt     = OWN_B;
                    burst_cnt_nxt = CNT_ONE;
                    last_b_nxt    = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                    last_b_nxt = 1'b0;
                end
            end
            OWN_B: begin
                if (b_req && !(a_req && burst_cnt == BURST_MAX)) begin
                    grant_b = 1'b1;
                    if (burst_cnt != BURST_MAX)
                        burst_cnt_nxt = burst_cnt + CNT_ONE;
                end else if (a_req) begin
                    grant_a       = 1'b1;
                    state_nxt     = OWN_A;
                    burst_cnt_nxt = CNT_ONE;
                    last_b_nxt    = 1'b0;
                end else begin
                    state_nxt  = IDLE;
                    last_b_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are masked by reset so they drop asynchronously with it
    assign a_gnt = grant_a & ~rst;
    assign b_gnt = grant_b & ~rst;

    // Forward the granted command straight to the memory pins
    assign mem_blk_select = a_gnt | b_gnt;
    assign mem_addr       = b_gnt ? b_addr  : a_addr;
    assign mem_din        = b_gnt ? b_wdata : a_wdata;
    assign mem_wr_en      = (a_gnt & a_we)  | (b_gnt & b_we);
    assign mem_rd_en      = (a_gnt & ~a_we) | (b_gnt & ~b_we);
    assign mem_addr_en    = 1'b0;
    assign mem_dout_en    = (RD_LATENCY == 2) ? 1'b1 : 1'b0;

    // In-flight read tracker: {valid, id} delayed to match memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld[0] <= mem_rd_en;
            rd_id[0]  <= b_gnt;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_id[i]  <= rd_id[i-1];
            end
        end
    end

    assign a_rvalid = rd_vld[LAST] & ~rd_id[LAST];
    assign b_rvalid = rd_vld[LAST] &  rd_id[LAST];

    // Last returned word per requester, shown while rvalid is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid) a_rdata_q <= mem_dout;
            if (b_rvalid) b_rdata_q <= mem_dout;
        end
    end

    assign a_rdata = a_rvalid ? mem_dout : a_rdata_q;
    assign b_rdata = b_rvalid ? mem_dout : b_rdata_q;

`ifdef SMEM_ARB_PARITY_CHK_EN
    logic parity_err_q;
    logic parity_err_sticky;
    logic parity_mismatch;

    // Memory parity is 1 when dout[0] is 0
    assign parity_mismatch = (a_rvalid | b_rvalid) & (mem_parity != ~mem_dout[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q      <= 1'b0;
            parity_err_sticky <= 1'b0;
        end else begin
            parity_err_q <= parity_mismatch;
            if (parity_mismatch) parity_err_sticky <= 1'b1;
        end
    end

    assign rd_parity_err = parity_err_q;
`else
    logic parity_unused;
    assign parity_unused = mem_parity;
    assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_smem_rr_arbiter.sv
// Testbench for smem_rr_arbiter: behavioural memory plus a transaction-level
// reference model (owner/run-length rules, shadow memory, read-return queue).
module tb_smem_rr_arbiter;

    localparam int unsigned MW  = 16;
    localparam int unsigned AW  = 10;
    localparam int unsigned RDL = 2;
    localparam int unsigned MB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [MW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [MW-1:0] a_rdata, b_rdata;
    logic [MW-1:0] mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en, mem_blk_select, mem_addr_en, mem_dout_en;
    logic          mem_parity, rd_parity_err;
    bit            force_bad_par = 1'b0;

    int checks = 0;
    int errors = 0;

    smem_rr_arbiter #(
        .MEM_WIDTH(MW), .ADDR_SIZE(AW), .RD_LATENCY(RDL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_din(mem_din), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_blk_select(mem_blk_select),
        .mem_addr_en(mem_addr_en), .mem_dout_en(mem_dout_en),
        .mem_dout(mem_dout), .mem_parity(mem_parity),
        .rd_parity_err(rd_parity_err)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory with RDL-cycle read latency
    logic [MW-1:0] mem_arr [0:(1<<AW)-1];
    logic [MW-1:0] rpipe   [0:RDL-1];
    always @(posedge clk) begin
        if (mem_blk_select && mem_wr_en) mem_arr[mem_addr] <= mem_din;
        if (mem_blk_select && mem_rd_en) rpipe[0] <= mem_arr[mem_addr];
        for (int i = 1; i < int'(RDL); i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_dout   = rpipe[RDL-1];
    assign mem_parity = force_bad_par ? 1'b0 : ~mem_dout[0];

    // Reference model state
    typedef struct {
        int            due;
        bit            id;
        logic [MW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [MW-1:0] shadow [0:(1<<AW)-1];
    int            cyc = 0;
    int            m_owner;   // 0 none, 1 A, 2 B
    int            m_last;    // 1 A, 2 B
    int            m_cnt;
    logic [MW-1:0] exp_ard, exp_brd;
    bit            exp_perr;
    bit            ga, gb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_owner  = 0;
        m_last   = 2;
        m_cnt    = 0;
        exp_ard  = '0;
        exp_brd  = '0;
        exp_perr = 1'b0;
    endtask

    // One clock cycle: predict, check at negedge, advance model, step past posedge
    task automatic step(output bit oga, output bit ogb);
        bit  ra, rb, mine, other, rva, rvb;
        int  g;
        rd_t e;
        @(negedge clk);
        ra = a_req; rb = b_req; oga = 1'b0; ogb = 1'b0;
        if (m_owner == 0) begin
            if (ra && rb) g = (m_last == 1) ? 2 : 1;
            else if (ra)  g = 1;
            else if (rb)  g = 2;
            else          g = 0;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (mine && !(other && m_cnt == int'(MB))) g = m_owner;
            else if (other)                            g = 3 - m_owner;
            else                                       g = 0;
        end
        oga = (g == 1);
        ogb = (g == 2);

        chk("a_gnt", a_gnt, oga);
        chk("b_gnt", b_gnt, ogb);
        chk("gnt_onehot", a_gnt & b_gnt, 0);
        chk("mem_blk_select", mem_blk_select, oga | ogb);
        chk("mem_rd_en", mem_rd_en, (oga && !a_we) || (ogb && !b_we));
        chk("mem_wr_en", mem_wr_en, (oga && a_we) || (ogb && b_we));
        if (oga || ogb) chk("mem_addr", mem_addr, oga ? a_addr : b_addr);

        rva = 1'b0; rvb = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            if (e.id) begin rvb = 1'b1; exp_brd = e.data; end
            else      begin rva = 1'b1; exp_ard = e.data; end
        end
        chk("a_rvalid", a_rvalid, rva);
        chk("b_rvalid", b_rvalid, rvb);
        chk("a_rdata", a_rdata, exp_ard);
        chk("b_rdata", b_rdata, exp_brd);
        chk("rd_parity_err", rd_parity_err, exp_perr);
`ifdef SMEM_ARB_PARITY_CHK_EN
        exp_perr = (rva || rvb) && (mem_parity !== ~mem_dout[0]);
`else
        exp_perr = 1'b0;
`endif

        if (oga) begin
            if (a_we) shadow[a_addr] = a_wdata;
            else rq.push_back('{due: cyc + int'(RDL), id: 1'b0, data: shadow[a_addr]});
        end
        if (ogb) begin
            if (b_we) shadow[b_addr] = b_wdata;
            else rq.push_back('{due: cyc + int'(RDL), id: 1'b1, data: shadow[b_addr]});
        end

        if (g != 0) begin
            if (g == m_owner) m_cnt = (m_cnt < int'(MB)) ? m_cnt + 1 : int'(MB);
            else begin
                if (m_owner != 0) m_last = g;
                m_owner = g;
                m_cnt   = 1;
            end
        end else if (m_owner != 0) begin
            m_last  = m_owner;
            m_owner = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit req, input bit we, input int addr, input logic [MW-1:0] d);
        a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = d;
    endtask

    task automatic drive_b(input bit req, input bit we, input int addr, input logic [MW-1:0] d);
        b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = d;
    endtask

    task automatic idle(input int n);
        drive_a(0, 0, 0, '0);
        drive_b(0, 0, 0, '0);
        for (int i = 0; i < n; i++) step(ga, gb);
    endtask

    initial begin
        bit pa, pb;
        rst = 1'b1;
        drive_a(0, 0, 0, '0);
        drive_b(0, 0, 0, '0);
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_parity_err", rd_parity_err, 0);
        chk("mem_addr_en", mem_addr_en, 0);
        chk("mem_dout_en", mem_dout_en, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // A write 0x1234 @5 then read it back
        drive_a(1, 1, 5, 16'h1234);
        step(ga, gb);
        drive_a(1, 0, 5, '0);
        step(ga, gb);
        idle(4);

        // Preload addr*3 for 0..15, then 10 back-to-back A reads of 0..9
        for (int i = 0; i < 16; i++) begin
            drive_a(1, 1, i, MW'(i * 3));
            step(ga, gb);
        end
        for (int i = 0; i < 10; i++) begin
            drive_a(1, 0, i, '0);
            step(ga, gb);
        end
        idle(4);

        // A writes 0xAAAA @1, B writes 0x5555 @2 (B is last owner afterwards)
        drive_a(1, 1, 1, 16'hAAAA);
        step(ga, gb);
        idle(1);
        drive_b(1, 1, 2, 16'h5555);
        step(ga, gb);
        idle(2);

        // Both requesting continuously from IDLE: bursts of MAX_BURST
        drive_a(1, 0, 1, '0);
        drive_b(1, 0, 2, '0);
        for (int i = 0; i < 12; i++) step(ga, gb);
        idle(4);

        // Alternating single-cycle requests
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin drive_a(1, 0, 1, '0); drive_b(0, 0, 0, '0); end
            else            begin drive_a(0, 0, 0, '0); drive_b(1, 0, 2, '0); end
            step(ga, gb);
        end
        idle(4);

        // Randomized traffic; commands held until granted
        pa = 1'b0; pb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1'b1;
                drive_a(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), MW'($urandom));
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1;
                drive_b(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), MW'($urandom));
            end
            a_req = pa;
            b_req = pb;
            step(ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        idle(4);

        // Parity: data 0x0002 returned with bad then good parity
        drive_a(1, 1, 20, 16'h0002);
        step(ga, gb);
        force_bad_par = 1'b1;
        drive_a(1, 0, 20, '0);
        step(ga, gb);
        idle(4);
        force_bad_par = 1'b0;
        drive_a(1, 0, 20, '0);
        step(ga, gb);
        idle(4);

        // Reset while two reads are in flight
        drive_a(1, 0, 3, '0);
        drive_b(0, 0, 0, '0);
        step(ga, gb);
        step(ga, gb);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_a_gnt", a_gnt, 0);
        chk("midrst_b_gnt", b_gnt, 0);
        chk("midrst_a_rvalid", a_rvalid, 0);
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        chk("midrst_a_rdata", a_rdata, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_hold_a_rvalid", a_rvalid, 0);
        chk("midrst_hold_a_gnt", a_gnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive_b(1, 0, 2, '0);
        step(ga, gb);
        chk("post_rst_first_grant_a", ga, 1);
        for (int i = 0; i < 6; i++) step(ga, gb);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smem_rr_arbiter.md
Name: smem_rr_arbiter

Overview:
- Arbiter sharing one single-port synchronous memory between two requesters, A and B.
- Round-robin ownership with a bounded burst length.
- Drives the memory command pins (din, addr, wr_en, rd_en, blk_select, addr_en, dout_en).
- Tracks in-flight reads and routes returned read data and parity back to the requester that issued each read.

Parameters:
- MEM_WIDTH, 16, data width; must match the memory.
- ADDR_SIZE, 10, address width; must match the memory.
- RD_LATENCY, 2, cycles from read issue to memory dout valid (1 = unpipelined dout, 2 = pipelined dout); legal values 1..4.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester is waiting; legal values 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A command valid.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  ADDR_SIZE  A address.
- a_wdata  in  MEM_WIDTH  A write data.
- a_gnt  out  1  A command accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  MEM_WIDTH  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A group, for requester B.
- mem_din  out  MEM_WIDTH  memory write data.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_blk_select  out  1  memory block select.
- mem_addr_en  out  1  tied 0 (no address pipelining).
- mem_dout_en  out  1  1 when RD_LATENCY==2, else 0.
- mem_dout  in  MEM_WIDTH  memory read data.
- mem_parity  in  1  memory parity (1 when mem_dout[0]==0).
- rd_parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (asynchronous): FSM = IDLE; last_owner = B, so A has first priority; burst_cnt = 0; read tracking pipe cleared; all gnt, rvalid, rdata, and mem enables = 0; rd_parity_err = 0.
- FSM states:
  - IDLE: no owner.
  - OWN_A / OWN_B: that requester is owner.
- Grant is combinational from the current state and the req inputs. The command is forwarded to the mem_* pins in the same cycle. mem_blk_select = a_gnt | b_gnt.
- IDLE:
  - Both requesting: grant the requester that is not last_owner. Next state = OWN_that; burst_cnt = 1.
  - One requesting: grant it; next state = OWN_that; burst_cnt = 1.
  - Neither requesting: stay in IDLE.
- OWN_X with X requesting:
  - If the other requester is requesting and burst_cnt == MAX_BURST: grant the other requester; next state = OWN_other; burst_cnt = 1; last_owner = other.
  - Otherwise: grant X; burst_cnt increments, saturating at MAX_BURST.
- OWN_X with X not requesting:
  - Other requester requesting: grant the other immediately (no dead cycle); switch owner as above.
  - Neither requesting: next state = IDLE; last_owner = X.
- burst_cnt is cleared to 1 on every ownership change. With only one requester active, burst_cnt never forces a switch.
- Exactly one gnt may be high per cycle. A command holds its fields until granted; a request with gnt=0 is not executed.
- Read tracking: a shift register RD_LATENCY deep, carrying {valid, id}, is loaded each cycle from {granted & ~we, granted_id}.
  - At the output stage: x_rvalid = 1 and x_rdata = mem_dout, for exactly one cycle, RD_LATENCY cycles after the grant.
  - Back-to-back reads from alternating requesters return in issue order with no gaps.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive grants returns the new data; memory write completes at the grant edge.
- x_rdata holds its last value when x_rvalid = 0.
- Reset mid-operation: in-flight reads are discarded (no rvalid issued) and ownership returns to IDLE.

Optional Feature:
- Macro: SMEM_ARB_PARITY_CHK_EN.
- Defined: at each rvalid, compute expected = ~mem_dout[0].
  - rd_parity_err is a registered one-cycle pulse, asserted the cycle after a mismatch with mem_parity.
  - Also sticky-recorded in an internal flag that only reset clears.
- Undefined: rd_parity_err tied 0; mem_parity is ignored.

Test Plan:
- Reset release; A writes 0x1234 @0x005; A reads @0x005 with RD_LATENCY=2 -> a_gnt same cycle as req; a_rvalid exactly 2 cycles after the read grant; a_rdata=0x1234; b_rvalid stays 0.
- A and B both request continuously from IDLE, MAX_BURST=4 -> grant sequence A,A,A,A,B,B,B,B,A...; never both gnt high.
- A only, 10 continuous reads of addr 0..9 (preloaded data=addr*3) -> 10 grants without a forced switch; a_rvalid for 10 consecutive cycles with data 0,3,...,27.
- Alternate A read @1 (=0xAAAA) and B read @2 (=0x5555) each cycle -> rvalid alternates a/b with correct data in order; no dropped or swapped responses.
- Assert rst while 2 reads are in flight -> gnt, rvalid, and mem_rd_en drop immediately (asynchronously); no rvalid after release; the next grant goes to A.
- With SMEM_ARB_PARITY_CHK_EN: force mem_parity=0 while mem_dout=0x0002 is returned -> rd_parity_err pulses 1 cycle; with mem_parity correct -> stays 0.
